// File: rtl/gpt_pkg.sv
// Shared types and constants for the general-purpose timer channels.
// Imported by the input capture channel and its filter.
package gpt_pkg;

    typedef enum logic [1:0] {
        CCS_OFF    = 2'b00,
        CCS_TI     = 2'b01,
        CCS_TI_ALT = 2'b10,
        CCS_RSVD   = 2'b11
    } ccs_e;

    typedef enum logic [1:0] {
        POL_RISING,
        POL_FALLING,
        POL_BOTH
    } pol_mode_e;

    typedef enum logic [1:0] {
        PSC_DIV1,
        PSC_DIV2,
        PSC_DIV4,
        PSC_DIV8
    } psc_e;

    localparam int FILT_W = 4;
    localparam int PSC_W  = 3;

    // Last edge index of each prescaler ratio; the capture fires on it.
    localparam logic [PSC_W-1:0] PSC_TOP [4] = '{3'd0, 3'd1, 3'd3, 3'd7};

    // The reserved 01 combination behaves as rising-edge.
    function automatic pol_mode_e pol_mode(input logic ccp, input logic ccnp);
        case ({ccp, ccnp})
            2'b10:   return POL_FALLING;
            2'b11:   return POL_BOTH;
            default: return POL_RISING;
        endcase
    endfunction

endpackage

// File: rtl/ic_input_filter.sv
// Two-flop synchronizer followed by an N-sample digital glitch filter.
// A new level is forwarded only after it has been seen len_i+1 times in a row.
module ic_input_filter
    import gpt_pkg::*;
(
    input  logic              clk_i,
    input  logic              aresetn_i,
    input  logic              in_i,
    input  logic [FILT_W-1:0] len_i,
    output logic              level_o
);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_level;
    logic [FILT_W-1:0] r_cnt;
    logic [FILT_W-1:0] r_len;

    // NOTE: every register here is state updated on the clock edge, so it
    // uses non-blocking assignments to avoid read/write ordering races.
    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_len   <= '0;
        end else begin
            r_sync1 <= in_i;
            r_sync2 <= r_sync1;
            r_len   <= len_i;
            // A length change or any sample matching the output restarts the run.
            if (len_i != r_len || r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt >= len_i) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level_o = r_level;

endmodule

// File: rtl/input_capture_channel.sv
// Timer capture channel input stage: source select, filter, edge detect,
// prescaler and capture register with flag, overcapture, IRQ and DMA handling.
module input_capture_channel
    import gpt_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 aresetn_i,
    input  logic [CNT_WIDTH-1:0] cnt_i,
    input  logic                 ti_i,
    input  logic                 ti_alt_i,
    input  logic [1:0]           ccs_i,
    input  logic                 cce_i,
    input  logic                 ccp_i,
    input  logic                 ccnp_i,
    input  logic [3:0]           icf_i,
    input  logic [1:0]           icpsc_i,
    input  logic                 ccie_i,
    input  logic                 ccde_i,
    input  logic                 ccr_rd_i,
    input  logic                 ccif_clr_i,
    input  logic                 ccof_clr_i,
    input  logic                 dack_i,
    output logic [CNT_WIDTH-1:0] ccr_o,
    output logic                 ccif_o,
    output logic                 ccof_o,
    output logic                 irq_o,
    output logic                 dreq_o,
    output logic                 tif_o,
    output logic                 ted_o
);

    ccs_e      w_ccs;
    pol_mode_e w_mode;
    psc_e      w_psc;
    logic      w_sel_in;
    logic      w_level;
    logic      w_rise;
    logic      w_fall;
    logic      w_ted;
    logic      w_active;
    logic      w_cap;

    logic                 r_level_q;
    logic [PSC_W-1:0]     r_psc;
    logic [CNT_WIDTH-1:0] r_ccr;
    logic                 r_ccif;
    logic                 r_ccof;
    logic                 r_dreq;

    assign w_ccs  = ccs_e'(ccs_i);
    assign w_psc  = psc_e'(icpsc_i);
    assign w_mode = pol_mode(ccp_i, ccnp_i);

    // NOTE: the default assignment ahead of the case keeps this purely
    // combinational; leaving a path unassigned would infer a latch.
    always_comb begin
        w_sel_in = 1'b0;
        case (w_ccs)
            CCS_TI:     w_sel_in = ti_i;
            CCS_TI_ALT: w_sel_in = ti_alt_i;
            default:    w_sel_in = 1'b0;
        endcase
    end

    ic_input_filter u_filter (
        .clk_i     (clk_i),
        .aresetn_i (aresetn_i),
        .in_i      (w_sel_in),
        .len_i     (icf_i),
        .level_o   (w_level)
    );

    // Edges are taken on the unpolarised level so a polarity change never fakes one.
    assign w_rise = w_level & ~r_level_q;
    assign w_fall = ~w_level & r_level_q;

    always_comb begin
        w_ted = w_rise;
        case (w_mode)
            POL_FALLING: w_ted = w_fall;
            POL_BOTH:    w_ted = w_rise | w_fall;
            default:     w_ted = w_rise;
        endcase
    end

    assign w_active = cce_i && (w_ccs == CCS_TI || w_ccs == CCS_TI_ALT);
    assign w_cap    = w_active && w_ted && (r_psc == PSC_TOP[w_psc]);

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            r_level_q <= 1'b0;
            r_psc     <= '0;
            r_ccr     <= '0;
            r_ccif    <= 1'b0;
            r_ccof    <= 1'b0;
            r_dreq    <= 1'b0;
        end else begin
            r_level_q <= w_level;

            if (!w_active) begin
                r_psc <= '0;
            end else if (w_ted) begin
                r_psc <= w_cap ? '0 : r_psc + 1'b1;
            end

            if (w_cap) begin
                r_ccr <= cnt_i;
            end

            // A capture in the same cycle always beats any clear source.
            if (w_cap) begin
                r_ccif <= 1'b1;
            end else if (ccif_clr_i || ccr_rd_i || dack_i) begin
                r_ccif <= 1'b0;
            end

            if (w_cap && r_ccif) begin
                r_ccof <= 1'b1;
            end else if (ccof_clr_i) begin
                r_ccof <= 1'b0;
            end

            if (w_cap && ccde_i) begin
                r_dreq <= 1'b1;
            end else if (dack_i) begin
                r_dreq <= 1'b0;
            end
        end
    end

    assign ccr_o  = r_ccr;
    assign ccif_o = r_ccif;
    assign ccof_o = r_ccof;
    assign dreq_o = r_dreq;
    assign irq_o  = r_ccif & ccie_i;
    assign ted_o  = w_ted;
    assign tif_o  = (w_mode == POL_FALLING) ? ~w_level : w_level;

endmodule

// File: tb/tb_input_capture_channel.sv
// Self-checking bench for input_capture_channel: directed scenarios plus a
// randomized run, all compared against a behavioural model of the channel.
module tb_input_capture_channel;

    localparam int CW = 32;

    logic          clk_i = 1'b0;
    logic          aresetn_i;
    logic [CW-1:0] cnt_i;
    logic          ti_i, ti_alt_i;
    logic [1:0]    ccs_i;
    logic          cce_i, ccp_i, ccnp_i;
    logic [3:0]    icf_i;
    logic [1:0]    icpsc_i;
    logic          ccie_i, ccde_i, ccr_rd_i, ccif_clr_i, ccof_clr_i, dack_i;
    logic [CW-1:0] ccr_o;
    logic          ccif_o, ccof_o, irq_o, dreq_o, tif_o, ted_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    input_capture_channel #(.CNT_WIDTH(CW)) dut (
        .clk_i(clk_i), .aresetn_i(aresetn_i), .cnt_i(cnt_i),
        .ti_i(ti_i), .ti_alt_i(ti_alt_i), .ccs_i(ccs_i), .cce_i(cce_i),
        .ccp_i(ccp_i), .ccnp_i(ccnp_i), .icf_i(icf_i), .icpsc_i(icpsc_i),
        .ccie_i(ccie_i), .ccde_i(ccde_i), .ccr_rd_i(ccr_rd_i),
        .ccif_clr_i(ccif_clr_i), .ccof_clr_i(ccof_clr_i), .dack_i(dack_i),
        .ccr_o(ccr_o), .ccif_o(ccif_o), .ccof_o(ccof_o), .irq_o(irq_o),
        .dreq_o(dreq_o), .tif_o(tif_o), .ted_o(ted_o)
    );

    // Reference model: input history per clock edge, filtered level decided
    // from run lengths in that history, edges counted against 2^psc.
    bit          m_hist [24];
    logic [CW-1:0] m_ccr;
    bit          m_ccif, m_ccof, m_dreq, m_filt, m_filt_old;
    int          m_age, m_icf_last, m_edges;

    task automatic model_reset();
        for (int i = 0; i < 24; i++) m_hist[i] = 1'b0;
        m_ccr = '0; m_ccif = 0; m_ccof = 0; m_dreq = 0;
        m_filt = 0; m_filt_old = 0;
        m_age = 100; m_icf_last = 0; m_edges = 0;
    endtask

    function automatic bit m_ted();
        if (ccp_i && ccnp_i) return m_filt != m_filt_old;
        if (ccp_i) return !m_filt && m_filt_old;
        return m_filt && !m_filt_old;
    endfunction

    task automatic model_update();
        bit active, cap, sel, run;
        active = cce_i && (ccs_i == 2'b01 || ccs_i == 2'b10);
        cap = 0;
        if (!active) m_edges = 0;
        else if (m_ted()) begin
            m_edges++;
            if (m_edges == (1 << icpsc_i)) begin
                cap = 1;
                m_edges = 0;
            end
        end
        if (cap && m_ccif) m_ccof = 1; else if (ccof_clr_i) m_ccof = 0;
        if (cap) m_ccif = 1; else if (ccif_clr_i || ccr_rd_i || dack_i) m_ccif = 0;
        if (cap && ccde_i) m_dreq = 1; else if (dack_i) m_dreq = 0;
        if (cap) m_ccr = cnt_i;

        sel = (ccs_i == 2'b01) ? ti_i : (ccs_i == 2'b10) ? ti_alt_i : 1'b0;
        for (int i = 23; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = sel;
        m_filt_old = m_filt;
        if (int'(icf_i) != m_icf_last) begin
            m_icf_last = int'(icf_i);
            m_age = 0;
        end else begin
            if (m_age < 100) m_age++;
            // Two synchronizer stages: the filter sees the sample from two edges ago.
            run = (m_age >= int'(icf_i) + 1);
            for (int i = 0; i <= int'(icf_i); i++)
                if (m_hist[2+i] == m_filt) run = 0;
            if (run) m_filt = !m_filt;
        end
    endtask

    function automatic logic [CW+5:0] exp_vec();
        bit tif;
        tif = (ccp_i && !ccnp_i) ? !m_filt : m_filt;
        return {m_ccr, m_ccif, m_ccof, m_dreq, m_ted(), tif, m_ccif & ccie_i};
    endfunction

    function automatic logic [CW+5:0] obs_vec();
        return {ccr_o, ccif_o, ccof_o, dreq_o, ted_o, tif_o, irq_o};
    endfunction

    // One clock: model steps on the edge, caller compares at the falling edge.
    task automatic tick();
        @(posedge clk_i);
        if (aresetn_i) model_update();
        @(negedge clk_i);
        cnt_i = cnt_i + 1;
    endtask

    task automatic test_reset();
        aresetn_i = 0; cnt_i = '0; ti_i = 0; ti_alt_i = 0; ccs_i = 2'b00;
        cce_i = 0; ccp_i = 0; ccnp_i = 0; icf_i = 0; icpsc_i = 0; ccie_i = 0;
        ccde_i = 0; ccr_rd_i = 0; ccif_clr_i = 0; ccof_clr_i = 0; dack_i = 0;
        model_reset();
        repeat (3) @(negedge clk_i);
        n_checks++;
        if (obs_vec() !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected 0", obs_vec());
        end
        aresetn_i = 1;
    endtask

    task automatic test_basic();
        logic [CW-1:0] c0;
        ccs_i = 2'b01; cce_i = 1; ccie_i = 1; cnt_i = 100;
        repeat (4) begin
            tick(); n_checks++;
            if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL basic_idle: got %h expected %h", obs_vec(), exp_vec()); end
        end
        ti_i = 1; c0 = cnt_i;
        for (int k = 1; k <= 7; k++) begin
            tick(); n_checks++;
            if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL basic_model k=%0d: got %h expected %h", k, obs_vec(), exp_vec()); end
            ccif_clr_i = 0;
            if (k == 3) begin
                n_checks++;
                if (ted_o !== 1'b1 || ccif_o !== 1'b0) begin n_fail++; $display("FAIL basic_ted_latency: ted=%b ccif=%b expected ted=1 ccif=0", ted_o, ccif_o); end
            end
            if (k == 4) begin
                n_checks++;
                if (ccif_o !== 1'b1 || irq_o !== 1'b1 || ccr_o !== c0 + 3) begin n_fail++; $display("FAIL basic_capture: ccif=%b irq=%b ccr=%0d expected 1 1 %0d", ccif_o, irq_o, ccr_o, c0 + 3); end
                ti_i = 0; ccif_clr_i = 1;
            end
        end
    endtask

    task automatic test_filter();
        logic [CW-1:0] c0, ccr_before;
        icf_i = 4;
        repeat (8) begin
            tick(); n_checks++;
            if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL filter_settle: got %h expected %h", obs_vec(), exp_vec()); end
        end
        ccr_before = ccr_o; ti_i = 1;
        for (int k = 1; k <= 13; k++) begin
            tick(); n_checks++;
            if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL filter_glitch_model k=%0d: got %h expected %h", k, obs_vec(), exp_vec()); end
            n_checks++;
            if (ted_o !== 1'b0 || ccr_o !== ccr_before) begin n_fail++; $display("FAIL filter_glitch k=%0d: ted=%b ccr=%0d expected 0 %0d", k, ted_o, ccr_o, ccr_before); end
            if (k == 3) ti_i = 0;
        end
        ti_i = 1; c0 = cnt_i;
        for (int k = 1; k <= 14; k++) begin
            tick(); n_checks++;
            if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL filter_pulse_model k=%0d: got %h expected %h", k, obs_vec(), exp_vec()); end
            if (k == 5) ti_i = 0;
            if (k == 7) begin
                n_checks++;
                if (ted_o !== 1'b1 || ccif_o !== 1'b0) begin n_fail++; $display("FAIL filter_ted: ted=%b ccif=%b expected 1 0", ted_o, ccif_o); end
            end
            if (k == 8) begin
                n_checks++;
                if (ccif_o !== 1'b1 || ccr_o !== c0 + 7) begin n_fail++; $display("FAIL filter_capture: ccif=%b ccr=%0d expected 1 %0d", ccif_o, ccr_o, c0 + 7); end
            end
        end
        icf_i = 0;
    endtask

    task automatic test_prescaler();
        int n_cap = 0;
        cce_i = 0; icpsc_i = 2;
        tick(); n_checks++;
        if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL psc_setup: got %h expected %h", obs_vec(), exp_vec()); end
        cce_i = 1; ccif_clr_i = 1; ccof_clr_i = 1;
        for (int e = 0; e < 8; e++) begin
            for (int ph = 0; ph < 2; ph++) begin
                int n;
                n = (e == 7 && ph == 1) ? 8 : int'($urandom_range(2, 5));
                ti_i = (ph == 0);
                for (int j = 0; j < n; j++) begin
                    tick(); n_checks++;
                    if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL psc_model e=%0d: got %h expected %h", e, obs_vec(), exp_vec()); end
                    ccif_clr_i = 0; ccof_clr_i = 0;
                    if (ccif_o) begin n_cap++; ccif_clr_i = 1; end
                end
            end
        end
        ccif_clr_i = 0;
        n_checks++;
        if (n_cap != 2) begin n_fail++; $display("FAIL psc_capture_count: got %0d expected 2", n_cap); end
        cce_i = 0; icpsc_i = 0;
        tick();
        cce_i = 1;
    endtask

    task automatic test_overcapture();
        logic [CW-1:0] c0;
        ccif_clr_i = 1; ccof_clr_i = 1;
        tick();
        ccif_clr_i = 0; ccof_clr_i = 0;
        for (int e = 0; e < 3; e++) begin
            ti_i = 1; c0 = cnt_i;
            for (int k = 1; k <= 6; k++) begin
                tick(); n_checks++;
                if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL ovr_model e=%0d k=%0d: got %h expected %h", e, k, obs_vec(), exp_vec()); end
                ccr_rd_i = (k == 3 && e == 2);
                if (k == 3) ti_i = 0;
                if (k == 4) begin
                    n_checks++;
                    if (ccif_o !== 1'b1 || ccof_o !== (e >= 1) || ccr_o !== c0 + 3) begin
                        n_fail++;
                        $display("FAIL ovr_capture e=%0d: ccif=%b ccof=%b ccr=%0d expected 1 %0d %0d", e, ccif_o, ccof_o, ccr_o, e >= 1, c0 + 3);
                    end
                end
            end
        end
    endtask

    task automatic test_dma();
        ccif_clr_i = 1; ccof_clr_i = 1;
        tick();
        ccif_clr_i = 0; ccof_clr_i = 0; ccde_i = 1; ti_i = 1;
        for (int k = 1; k <= 9; k++) begin
            tick(); n_checks++;
            if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL dma_model k=%0d: got %h expected %h", k, obs_vec(), exp_vec()); end
            dack_i = 0;
            if (k == 3) ti_i = 0;
            if (k == 4 || k == 7) begin
                n_checks++;
                if (dreq_o !== 1'b1 || ccif_o !== 1'b1) begin n_fail++; $display("FAIL dma_request k=%0d: dreq=%b ccif=%b expected 1 1", k, dreq_o, ccif_o); end
            end
            if (k == 7) dack_i = 1;
            if (k == 8) begin
                n_checks++;
                if (dreq_o !== 1'b0 || ccif_o !== 1'b0) begin n_fail++; $display("FAIL dma_ack: dreq=%b ccif=%b expected 0 0", dreq_o, ccif_o); end
            end
        end
        ccde_i = 0;
    endtask

    task automatic test_reset_both_edges();
        int n_cap = 0;
        ccp_i = 1; ccnp_i = 1;
        for (int k = 0; k < 10; k++) begin
            tick(); n_checks++;
            if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL burst_model: got %h expected %h", obs_vec(), exp_vec()); end
            ti_i = ~ti_i;
        end
        aresetn_i = 0; ti_i = 0;
        #1;
        n_checks++;
        if (obs_vec() !== '0) begin n_fail++; $display("FAIL reset_midburst: got %h expected 0", obs_vec()); end
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        aresetn_i = 1;
        for (int e = 0; e < 6; e++) begin
            int n;
            n = (e == 5) ? 8 : int'($urandom_range(3, 6));
            ti_i = ~ti_i;
            for (int j = 0; j < n; j++) begin
                tick(); n_checks++;
                if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL both_model e=%0d: got %h expected %h", e, obs_vec(), exp_vec()); end
                ccif_clr_i = 0;
                if (ccif_o) begin n_cap++; ccif_clr_i = 1; end
            end
        end
        ccif_clr_i = 0;
        n_checks++;
        if (n_cap != 6) begin n_fail++; $display("FAIL both_capture_count: got %0d expected 6", n_cap); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            tick(); n_checks++;
            if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL random_model k=%0d: got %h expected %h", k, obs_vec(), exp_vec()); end
            if ($urandom_range(0, 3) == 0) ti_i = ~ti_i;
            if ($urandom_range(0, 3) == 0) ti_alt_i = ~ti_alt_i;
            if ($urandom_range(0, 99) == 0) icf_i = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) ccs_i = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 79) == 0) begin
                cce_i = 0;
                icpsc_i = 2'($urandom_range(0, 3));
                ccp_i = 1'($urandom_range(0, 1));
                ccnp_i = 1'($urandom_range(0, 1));
            end else begin
                cce_i = 1;
            end
            ccif_clr_i = ($urandom_range(0, 7) == 0);
            ccof_clr_i = ($urandom_range(0, 7) == 0);
            ccr_rd_i   = ($urandom_range(0, 9) == 0);
            dack_i     = ($urandom_range(0, 7) == 0);
            ccie_i     = 1'($urandom_range(0, 1));
            ccde_i     = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_filter();
        test_prescaler();
        test_overcapture();
        test_dma();
        test_reset_both_edges();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
